// File: rtl/frac_baud_generator.sv
// Fractional-N baud generator: emits oversample, bit-centre and bit-period ticks
// from a shadowed integer + fractional clock divisor.
module frac_baud_generator #(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned FRAC_W      = 4,
    parameter int unsigned OSR         = 16,
    parameter int unsigned DEFAULT_DIV = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              cfg_err
);

    localparam int unsigned OS_W = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OSR / 2 - 1);

    logic [DIV_W-1:0]  div_int_q;
    logic [FRAC_W-1:0] div_frac_q;
    logic [DIV_W-1:0]  cnt_q;
    logic [FRAC_W-1:0] acc_q;
    logic              ext_q;
    logic [OS_W-1:0]   os_cnt_q;

    logic [DIV_W-1:0]  limit;
    logic [FRAC_W:0]   acc_sum;

    // ext stretches the current period by one cycle after a phase carry
    assign limit   = div_int_q - DIV_W'(1) + {{(DIV_W-1){1'b0}}, ext_q};
    assign acc_sum = {1'b0, acc_q} + {1'b0, div_frac_q};

    assign cfg_err  = (div_int_q == '0);
    assign os_tick  = en & ~load & ~cfg_err & (cnt_q == limit);
    assign bit_tick = os_tick & (os_cnt_q == OS_LAST);
    assign mid_tick = os_tick & (os_cnt_q == OS_MID);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_int_q  <= DIV_W'(DEFAULT_DIV);
            div_frac_q <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            ext_q      <= 1'b0;
            os_cnt_q   <= '0;
        end else if (load) begin
            // load wins over a coincident terminal count and restarts phase
            div_int_q  <= div_int;
            div_frac_q <= div_frac;
            cnt_q      <= '0;
            acc_q      <= '0;
            ext_q      <= 1'b0;
            os_cnt_q   <= '0;
        end else if (os_tick) begin
            cnt_q    <= '0;
            acc_q    <= acc_sum[FRAC_W-1:0];
            ext_q    <= acc_sum[FRAC_W];
            os_cnt_q <= (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
        end else if (en && !cfg_err) begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: tb/tb_frac_baud_generator.sv
// Directed self-checking bench for frac_baud_generator (default parameters).
module tb_frac_baud_generator;

    localparam int unsigned DIV_W       = 16;
    localparam int unsigned FRAC_W      = 4;
    localparam int unsigned OSR         = 16;
    localparam int unsigned DEFAULT_DIV = 27;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              load;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              os_tick;
    logic              mid_tick;
    logic              bit_tick;
    logic              cfg_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    frac_baud_generator #(
        .DIV_W      (DIV_W),
        .FRAC_W     (FRAC_W),
        .OSR        (OSR),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .div_int (div_int),
        .div_frac(div_frac),
        .os_tick (os_tick),
        .mid_tick(mid_tick),
        .bit_tick(bit_tick),
        .cfg_err (cfg_err)
    );

    // Called at a falling edge; returns at the falling edge of the first cycle after load.
    task automatic do_load(input logic [DIV_W-1:0] di, input logic [FRAC_W-1:0] df);
        load     = 1'b1;
        div_int  = di;
        div_frac = df;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        int first;
        int count;
        rst = 1'b1; en = 1'b0; load = 1'b0; div_int = '0; div_frac = '0;
        #3;
        tests_run++;
        if ({os_tick, mid_tick, bit_tick, cfg_err} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want 0000", {os_tick, mid_tick, bit_tick, cfg_err});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        first = 0;
        count = 0;
        for (int i = 1; i <= 40; i++) begin
            #1;
            if (i == 1) begin
                tests_run++;
                if ({os_tick, mid_tick, bit_tick, cfg_err} !== 4'b0000) begin
                    tests_failed++;
                    $display("FAIL post_reset_cycle: got %b want 0000",
                             {os_tick, mid_tick, bit_tick, cfg_err});
                end
            end
            if (os_tick) begin
                count++;
                if (first == 0) first = i;
            end
            @(negedge clk);
        end
        tests_run++;
        if (first !== 27 || count !== 1) begin
            tests_failed++;
            $display("FAIL default_rate: first tick %0d count %0d, want 27 and 1", first, count);
        end
    endtask

    task automatic test_integer_rate();
        logic [2:0] exp_t;
        do_load(16'd4, 4'd0);
        for (int i = 1; i <= 128; i++) begin
            #1;
            exp_t = {(i % 4) == 0, (i % 64) == 32, (i % 64) == 0};
            tests_run++;
            if ({os_tick, mid_tick, bit_tick} !== exp_t) begin
                tests_failed++;
                $display("FAIL integer_rate cycle %0d: got os/mid/bit %b want %b",
                         i, {os_tick, mid_tick, bit_tick}, exp_t);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fractional_rate();
        int os_q[$];
        int mid_q[$];
        int bit_q[$];
        int exp_os[16] = '{3, 6, 10, 13, 17, 20, 24, 27, 31, 34, 38, 41, 45, 48, 52, 55};
        int got;
        do_load(16'd3, 4'd8);
        for (int i = 1; i <= 112; i++) begin
            #1;
            if (os_tick) os_q.push_back(i);
            if (mid_tick) mid_q.push_back(i);
            if (bit_tick) bit_q.push_back(i);
            @(negedge clk);
        end
        tests_run++;
        if (os_q.size() != 32) begin
            tests_failed++;
            $display("FAIL frac_os_count: got %0d want 32", os_q.size());
        end
        for (int j = 0; j < 16; j++) begin
            got = (j < os_q.size()) ? os_q[j] : -1;
            tests_run++;
            if (got != exp_os[j]) begin
                tests_failed++;
                $display("FAIL frac_os_pos[%0d]: got %0d want %0d", j, got, exp_os[j]);
            end
        end
        tests_run++;
        if (mid_q.size() != 2 || mid_q[0] != 27 || mid_q[1] != 83) begin
            tests_failed++;
            $display("FAIL frac_mid: got %p want 27,83", mid_q);
        end
        tests_run++;
        if (bit_q.size() != 2 || bit_q[0] != 55 || bit_q[1] != 111) begin
            tests_failed++;
            $display("FAIL frac_bit: got %p want 55,111", bit_q);
        end
    endtask

    task automatic test_enable_gating();
        int seen;
        int first;
        do_load(16'd4, 4'd0);
        for (int i = 1; i <= 2; i++) begin
            #1;
            @(negedge clk);
        end
        en = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (os_tick || mid_tick || bit_tick) seen++;
            @(negedge clk);
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL gated_ticks: got %0d tick cycles want 0", seen);
        end
        en = 1'b1;
        first = 0;
        for (int i = 1; i <= 6; i++) begin
            #1;
            if (os_tick && first == 0) first = i;
            @(negedge clk);
        end
        tests_run++;
        if (first != 2) begin
            tests_failed++;
            $display("FAIL gated_resume: first tick %0d want 2", first);
        end
    endtask

    task automatic test_reload_priority();
        int first_os;
        int first_mid;
        int first_bit;
        do_load(16'd4, 4'd0);
        for (int i = 1; i <= 23; i++) begin
            #1;
            @(negedge clk);
        end
        // cycle 24 is a terminal count under div 4
        load = 1'b1; div_int = 16'd5; div_frac = 4'd0;
        #1;
        tests_run++;
        if ({os_tick, mid_tick, bit_tick} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reload_priority: got %b want 000", {os_tick, mid_tick, bit_tick});
        end
        @(negedge clk);
        load = 1'b0;
        first_os = 0; first_mid = 0; first_bit = 0;
        for (int i = 1; i <= 80; i++) begin
            #1;
            if (os_tick && first_os == 0) first_os = i;
            if (mid_tick && first_mid == 0) first_mid = i;
            if (bit_tick && first_bit == 0) first_bit = i;
            @(negedge clk);
        end
        tests_run++;
        if (first_os != 5) begin
            tests_failed++;
            $display("FAIL reload_first_os: got %0d want 5", first_os);
        end
        tests_run++;
        if (first_mid != 40 || first_bit != 80) begin
            tests_failed++;
            $display("FAIL reload_os_cnt: mid %0d bit %0d want 40 and 80", first_mid, first_bit);
        end
    endtask

    task automatic test_cfg_err();
        int err_low;
        int ticks;
        int first_mid;
        int first_bit;
        do_load(16'd0, 4'd0);
        err_low = 0; ticks = 0;
        for (int i = 1; i <= 100; i++) begin
            #1;
            if (cfg_err !== 1'b1) err_low++;
            if (os_tick || mid_tick || bit_tick) ticks++;
            @(negedge clk);
        end
        tests_run++;
        if (err_low != 0) begin
            tests_failed++;
            $display("FAIL cfg_err_high: got %0d low cycles want 0", err_low);
        end
        tests_run++;
        if (ticks != 0) begin
            tests_failed++;
            $display("FAIL cfg_err_no_ticks: got %0d tick cycles want 0", ticks);
        end
        do_load(16'd1, 4'd0);
        err_low = 0; ticks = 0; first_mid = 0; first_bit = 0;
        for (int i = 1; i <= 20; i++) begin
            #1;
            if (cfg_err === 1'b0) err_low++;
            if (os_tick === 1'b1) ticks++;
            if (mid_tick && first_mid == 0) first_mid = i;
            if (bit_tick && first_bit == 0) first_bit = i;
            @(negedge clk);
        end
        tests_run++;
        if (err_low != 20 || ticks != 20) begin
            tests_failed++;
            $display("FAIL div1_every_cycle: cfg_err low %0d os ticks %0d want 20 and 20",
                     err_low, ticks);
        end
        tests_run++;
        if (first_mid != 8 || first_bit != 16) begin
            tests_failed++;
            $display("FAIL div1_mid_bit: mid %0d bit %0d want 8 and 16", first_mid, first_bit);
        end
    endtask

    task automatic test_async_reset();
        int first;
        do_load(16'd0, 4'd0);
        #1;
        tests_run++;
        if (cfg_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_precondition: cfg_err %b want 1", cfg_err);
        end
        for (int pass = 0; pass < 2; pass++) begin
            // pulse lies entirely between edges
            if (pass == 1) #1;
            rst = 1'b1;
            #1;
            tests_run++;
            if ({os_tick, mid_tick, bit_tick, cfg_err} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL async_reset_outputs pass %0d: got %b want 0000",
                         pass, {os_tick, mid_tick, bit_tick, cfg_err});
            end
            #1;
            rst = 1'b0;
            #1;
            tests_run++;
            if ({os_tick, mid_tick, bit_tick, cfg_err} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL async_release_cycle pass %0d: got %b want 0000",
                         pass, {os_tick, mid_tick, bit_tick, cfg_err});
            end
            @(negedge clk);
            first = 0;
            for (int i = 2; i <= 40; i++) begin
                #1;
                if (os_tick && first == 0) first = i;
                @(negedge clk);
            end
            tests_run++;
            if (first != 27) begin
                tests_failed++;
                $display("FAIL async_restart pass %0d: first tick %0d want 27", pass, first);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_integer_rate();
        test_fractional_rate();
        test_enable_gating();
        test_reload_priority();
        test_cfg_err();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/frac_baud_generator.md
FRAC_BAUD_GENERATOR -- requirements
Module: frac_baud_generator

Interface
REQ-001 Parameter DIV_W, default 16: width of the integer divisor and period counter; SHALL be >= 2.
REQ-002 Parameter FRAC_W, default 4: width of the fractional divisor and phase accumulator; SHALL be >= 1.
REQ-003 Parameter OSR, default 16: os_ticks per bit period; SHALL be an even value >= 4.
REQ-004 Parameter DEFAULT_DIV, default 27: integer divisor loaded at reset; fractional part resets to 0.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  count enable; when low, all counters hold.
REQ-008 load  input  1  single-cycle strobe; captures div_int/div_frac into the shadow registers and restarts phase.
REQ-009 div_int  input  DIV_W  integer part of clk cycles per os_tick.
REQ-010 div_frac  input  FRAC_W  fractional part of clk cycles per os_tick, in units of 2^-FRAC_W.
REQ-011 os_tick  output  1  oversample tick, one clk wide.
REQ-012 mid_tick  output  1  bit-centre sample tick, one clk wide.
REQ-013 bit_tick  output  1  bit-period tick, one clk wide.
REQ-014 cfg_err  output  1  high while the shadow integer divisor is 0.

Function
REQ-015 Shadow registers div_int_q (DIV_W) and div_frac_q (FRAC_W) SHALL be the only divisor source; div_int/div_frac are sampled only on load.
REQ-016 State: cnt (DIV_W), acc (FRAC_W), ext (1), os_cnt (clog2(OSR)).
REQ-017 limit = div_int_q - 1 + ext; no overflow is possible because div_int_q >= 1 whenever counting.
REQ-018 os_tick SHALL equal en & !load & !cfg_err & (cnt == limit), decoded from registered state.
REQ-019 On an os_tick cycle: cnt <= 0; {carry, acc} <= acc + div_frac_q; ext <= carry; os_cnt wraps OSR-1 -> 0, else increments.
REQ-020 On an enabled cycle without os_tick, cnt SHALL increment and acc/ext/os_cnt SHALL hold.
REQ-021 Resulting os_tick period: div_int_q + ext cycles; long-run average div_int_q + div_frac_q/2^FRAC_W cycles.
REQ-022 bit_tick SHALL equal os_tick & (os_cnt == OSR-1).
REQ-023 mid_tick SHALL equal os_tick & (os_cnt == OSR/2 - 1).
REQ-024 With en low, no counter SHALL change and all ticks SHALL be 0.
REQ-025 On load, independent of en: the shadows capture the inputs, cnt/acc/ext/os_cnt clear to 0, and no tick fires that cycle; load SHALL take priority over a coincident terminal count.
REQ-026 cfg_err SHALL be (div_int_q == 0), combinational; while it is high, all counters hold and all ticks are 0.
REQ-027 div_int_q == 1 with div_frac_q == 0 SHALL give os_tick high on every enabled cycle.
REQ-028 Tick relationships: bit_tick and mid_tick SHALL never assert without os_tick, and SHALL never assert together.

Reset
REQ-029 rst high SHALL asynchronously force div_int_q=DEFAULT_DIV, div_frac_q=0, cnt=0, acc=0, ext=0, os_cnt=0.
REQ-030 During reset and in the first cycle after it, os_tick, mid_tick, bit_tick and cfg_err SHALL all be 0.
REQ-031 Reset asserted mid-period SHALL discard phase immediately; counting resumes from cnt=0 after release.

Verification
REQ-032 Integer rate: load div_int=4, div_frac=0, en=1, OSR=16 -> os_tick every 4th cycle, first on the 4th enabled cycle; mid_tick at cycle 32; bit_tick every 64 cycles.
REQ-033 Fractional rate: load div_int=3, div_frac=8, FRAC_W=4 -> os_tick periods 3,3,4,3,4,...; first bit_tick at enabled cycle 55, then every 56 cycles.
REQ-034 Enable gating: drop en for 10 cycles mid-period at cnt=2 -> ticks suppressed, cnt stays 2; the next os_tick follows the remaining period exactly.
REQ-035 Reload priority: assert load on the cycle cnt==limit with div_int=5 -> no os_tick that cycle; the next os_tick comes 5 enabled cycles later and os_cnt restarts at 0.
REQ-036 Config error: load div_int=0 -> cfg_err=1 and no ticks for 100 cycles; load div_int=1, div_frac=0 -> cfg_err=0 and os_tick high every enabled cycle.
REQ-037 Async reset: pulse rst between clock edges mid-operation -> state returns to DEFAULT_DIV/0 values without waiting for a clock edge; with en=1, the first os_tick after release comes DEFAULT_DIV cycles later.
